// File: rtl/temp_sense_filter.sv
// Temperature front-end: moving average over DEPTH quarter-degree samples with outlier
// rejection, producing a saturated whole-degree reading for the AC controller.
module temp_sense_filter #(
    parameter int unsigned DEPTH        = 4,  // 2, 4 or 8
    parameter int unsigned MAX_STEP     = 4,
    parameter int unsigned REJECT_LIMIT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_valid,
    input  logic [7:0] sample_data,
    output logic       sample_ready,
    output logic [4:0] temperature,
    output logic       temp_valid,
    output logic       outlier
);

    localparam int unsigned LogD = $clog2(DEPTH);
    localparam int unsigned SumW = 8 + LogD;
    localparam int unsigned RejW = (REJECT_LIMIT > 1) ? $clog2(REJECT_LIMIT) : 1;

    typedef enum logic {StFill, StRun} state_e;

    state_e            state_q, state_d;
    logic [7:0]        window_q [DEPTH];
    logic [7:0]        window_d [DEPTH];
    logic [SumW-1:0]   sum_q, sum_d;
    logic [LogD-1:0]   fill_q, fill_d;
    logic [RejW-1:0]   rej_q, rej_d;
    logic [4:0]        temperature_q, temperature_d;
    logic              temp_valid_q, temp_valid_d;
    logic              outlier_q, outlier_d;
    logic              ready_q;

    logic              accept;
    logic [9:0]        samp_ext, ref_ext, abs_diff;
    logic              is_outlier;
    logic [7:0]        avg_q;
    logic [6:0]        deg;
    logic [4:0]        deg_sat;

    assign accept   = sample_valid && ready_q;

    // Outlier test is against the registered temperature, even if one update stale.
    assign samp_ext   = {2'b00, sample_data};
    assign ref_ext    = {3'b000, temperature_q, 2'b00};
    assign abs_diff   = (samp_ext >= ref_ext) ? (samp_ext - ref_ext) : (ref_ext - samp_ext);
    assign is_outlier = 32'(abs_diff) > (4 * MAX_STEP);

    assign avg_q   = 8'(sum_q >> LogD);
    assign deg     = 7'((9'(avg_q) + 9'd2) >> 2);
    assign deg_sat = (deg > 7'd31) ? 5'd31 : deg[4:0];

    always_comb begin
        state_d       = state_q;
        window_d      = window_q;
        sum_d         = sum_q;
        fill_d        = fill_q;
        rej_d         = rej_q;
        outlier_d     = 1'b0;
        temperature_d = (state_q == StRun) ? deg_sat : temperature_q;
        temp_valid_d  = temp_valid_q | (state_q == StRun);

        if (accept) begin
            unique case (state_q)
                StFill: begin
                    sum_d       = sum_q - SumW'(window_q[DEPTH-1]) + SumW'(sample_data);
                    window_d[0] = sample_data;
                    for (int i = 1; i < DEPTH; i++) window_d[i] = window_q[i-1];
                    fill_d = fill_q + LogD'(1);
                    if (32'(fill_q) == DEPTH - 1) state_d = StRun;
                end
                StRun: begin
                    if (!is_outlier) begin
                        sum_d       = sum_q - SumW'(window_q[DEPTH-1]) + SumW'(sample_data);
                        window_d[0] = sample_data;
                        for (int i = 1; i < DEPTH; i++) window_d[i] = window_q[i-1];
                        rej_d = '0;
                    end else if (32'(rej_q) + 1 < REJECT_LIMIT) begin
                        rej_d     = rej_q + RejW'(1);
                        outlier_d = 1'b1;
                    end else begin
                        // Persistent deviation is a real step: re-seed the whole window.
                        for (int i = 0; i < DEPTH; i++) window_d[i] = sample_data;
                        sum_d = SumW'(sample_data) << LogD;
                        rej_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StFill;
            for (int i = 0; i < DEPTH; i++) window_q[i] <= '0;
            sum_q         <= '0;
            fill_q        <= '0;
            rej_q         <= '0;
            temperature_q <= '0;
            temp_valid_q  <= 1'b0;
            outlier_q     <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            window_q      <= window_d;
            sum_q         <= sum_d;
            fill_q        <= fill_d;
            rej_q         <= rej_d;
            temperature_q <= temperature_d;
            temp_valid_q  <= temp_valid_d;
            outlier_q     <= outlier_d;
            ready_q       <= 1'b1;
        end
    end

    assign sample_ready = ready_q;
    assign temperature  = temperature_q;
    assign temp_valid   = temp_valid_q;
    assign outlier      = outlier_q;

endmodule
